// File: rtl/uart_rx_top.sv
// UART receiver: 2-flop line synchroniser, oversampling 8N1 deserialiser and
// a first-word-fall-through receive FIFO read through the bus data register.
module uart_rx_top #(
  parameter int FIFO_DEPTH = 32
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        UART_Kontrol_Yazmaci_rx_Active,
  input  logic        UART_Veri_Okuma_Yazmaci_enable,
  input  logic [15:0] baud_div,
  input  logic        uart_rx_i,
  output logic [7:0]  UART_Veri_Okuma_Yazmaci_rdata,
  output logic        UART_Durum_Yazmaci_rx_full,
  output logic        UART_Durum_Yazmaci_rx_empty,
  output logic        rx_frame_err_o,
  output logic        rx_overrun_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nx;
  logic        sync1, rx_s;
  logic        prev_high;
  logic [15:0] cnt;
  logic [15:0] half_m1, full_m1;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        cnt_clr, shift_en, push, frame_err;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, pop, push_ok, overrun;

  assign half_m1 = (baud_div >> 1) - 16'd1;
  assign full_m1 = baud_div - 16'd1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= uart_rx_i;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    push      = 1'b0;
    frame_err = 1'b0;
    if (!UART_Kontrol_Yazmaci_rx_Active) begin
      state_nx = IDLE;
      cnt_clr  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt_clr = 1'b1;
          // A start needs a high-to-low transition, so a held break cannot retrigger.
          if (prev_high && !rx_s) state_nx = START;
        end
        START: begin
          if (cnt == half_m1) begin
            cnt_clr  = 1'b1;
            state_nx = rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt == full_m1) begin
            cnt_clr  = 1'b1;
            shift_en = 1'b1;
            if (bit_idx == 3'd7) state_nx = STOP;
          end
        end
        STOP: begin
          if (cnt == full_m1) begin
            cnt_clr  = 1'b1;
            state_nx = IDLE;
            if (rx_s) push = 1'b1;
            else      frame_err = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      prev_high <= 1'b0;
    end else begin
      cnt       <= cnt_clr ? '0 : cnt + 16'd1;
      prev_high <= (state == IDLE) && rx_s;
      if (state != DATA)  bit_idx <= '0;
      else if (shift_en)  bit_idx <= bit_idx + 3'd1;
      if (shift_en)       shreg   <= {rx_s, shreg[7:1]};
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = UART_Veri_Okuma_Yazmaci_enable && !empty;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign push_ok = push && (!full || pop);
  assign overrun = push && full && !pop;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rx_frame_err_o <= 1'b0;
      rx_overrun_o   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      rx_frame_err_o <= frame_err;
      rx_overrun_o   <= overrun;
    end
  end

  assign UART_Veri_Okuma_Yazmaci_rdata = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign UART_Durum_Yazmaci_rx_full    = full;
  assign UART_Durum_Yazmaci_rx_empty   = empty;

endmodule

// File: tb/tb_uart_rx_top.sv
// Randomised scoreboard bench for uart_rx_top: stimulus queues expected bytes
// and pulses, a negedge monitor compares reads and pulses as they appear.
module tb_uart_rx_top;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rstn, active, en, line;
  logic [15:0] bd;
  logic [7:0]  rdata;
  logic        rx_full, rx_empty, ferr, ovr;
  logic        ferr_d, ovr_d;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_rd_q[$];
  logic [7:0] exp_evt_q[$];

  uart_rx_top #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i                          (clk),
    .rstn_i                         (rstn),
    .UART_Kontrol_Yazmaci_rx_Active (active),
    .UART_Veri_Okuma_Yazmaci_enable (en),
    .baud_div                       (bd),
    .uart_rx_i                      (line),
    .UART_Veri_Okuma_Yazmaci_rdata  (rdata),
    .UART_Durum_Yazmaci_rx_full     (rx_full),
    .UART_Durum_Yazmaci_rx_empty    (rx_empty),
    .rx_frame_err_o                 (ferr),
    .rx_overrun_o                   (ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic evt(input logic [7:0] kind);
    if (exp_evt_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_pulse: got %c expected none at %0t", kind, $time);
    end else begin
      chk("pulse_kind", kind, exp_evt_q.pop_front());
    end
  endtask

  // Monitor: compare every accepted read and every status pulse.
  always @(negedge clk) begin
    if (rstn) begin
      if (en && !rx_empty) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_read: got %0h expected nothing at %0t", rdata, $time);
        end else begin
          chk("read_data", rdata, exp_rd_q.pop_front());
        end
      end
      if (ferr) evt("E");
      if (ovr)  evt("O");
      if (ferr && ferr_d) chk("ferr_width", 2, 1);
      if (ovr && ovr_d)   chk("ovr_width", 2, 1);
    end
    ferr_d = ferr;
    ovr_d  = ovr;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_read();
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
  endtask

  // Model: frame outcome is decided from the FIFO occupancy at send time.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input bit pop_at_push, input int abort_bit, input bit track);
    logic [9:0] bits;
    int unsigned h;
    bits = {stop_bit, data, 1'b0};
    h = int'(bd >> 1);
    if (track && abort_bit < 0) begin
      if (!stop_bit)                                    exp_evt_q.push_back("E");
      else if (exp_rd_q.size() < DEPTH || pop_at_push)  exp_rd_q.push_back(data);
      else                                              exp_evt_q.push_back("O");
    end
    for (int b = 0; b < 10; b++) begin
      for (int unsigned j = 0; j < int'(bd); j++) begin
        @(posedge clk); #1;
        if (j == 0) line = bits[b];
        if (pop_at_push) en = (b == 9) && (j == h + 2);
        if (abort_bit >= 0 && b == abort_bit + 1 && j == int'(bd) / 2) active = 1'b0;
      end
    end
    @(posedge clk); #1;
    line = 1'b1;
    en   = 1'b0;
    if (abort_bit >= 0) begin
      idle(4);
      active = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdata"}, rdata, 8'h00);
    chk({tag, "_empty"}, rx_empty, 1);
    chk({tag, "_full"},  rx_full, 0);
    chk({tag, "_ferr"},  ferr, 0);
    chk({tag, "_ovr"},   ovr, 0);
  endtask

  initial begin
    bit found;
    rstn = 1'b0; active = 1'b1; en = 1'b0; line = 1'b1; bd = 16'd16;
    ferr_d = 1'b0; ovr_d = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    rstn = 1'b1;
    idle(5);

    // Single byte with latency bound from the start edge
    found = 1'b0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b1);
      begin
        for (int k = 0; k < 170; k++) begin
          @(posedge clk); #2;
          if (!rx_empty) begin found = 1'b1; break; end
        end
        chk("a5_latency_found", found, 1);
      end
    join
    chk("a5_rdata", rdata, 8'hA5);
    do_read();
    chk("a5_empty_after_read", rx_empty, 1);
    chk("a5_rdata_after_read", rdata, 8'h00);
    do_read();
    chk("pop_on_empty_ignored", rx_empty, 1);

    // Glitch: too short to survive the half-bit check
    line = 1'b0; idle(4); line = 1'b1;
    idle(40);
    chk("glitch_empty", rx_empty, 1);

    // Framing error
    send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b1);
    idle(40);
    chk("ferr_empty", rx_empty, 1);

    // Fill, overrun, simultaneous push/pop at full
    for (int i = 0; i < 32; i++) send_frame(8'(i), 1'b1, 1'b0, -1, 1'b1);
    idle(20);
    chk("fill_full", rx_full, 1);
    chk("fill_head", rdata, 8'h00);
    send_frame(8'hFF, 1'b1, 1'b0, -1, 1'b1);
    idle(20);
    chk("overrun_full", rx_full, 1);
    chk("overrun_head", rdata, 8'h00);
    send_frame(8'h77, 1'b1, 1'b1, -1, 1'b1);
    idle(20);
    chk("simul_full", rx_full, 1);
    chk("simul_head", rdata, 8'h01);
    for (int i = 0; i < 32; i++) do_read();
    chk("drain_empty", rx_empty, 1);
    chk("drain_not_full", rx_full, 0);

    // Receiver disabled mid-frame, then a clean frame
    send_frame(8'h99, 1'b1, 1'b0, 3, 1'b1);
    idle(40);
    chk("abort_empty", rx_empty, 1);
    send_frame(8'h5A, 1'b1, 1'b0, -1, 1'b1);
    idle(20);
    chk("reenable_rdata", rdata, 8'h5A);
    do_read();

    // Asynchronous reset mid-frame with a byte already buffered
    send_frame(8'h11, 1'b1, 1'b0, -1, 1'b1);
    idle(20);
    chk("prereset_rdata", rdata, 8'h11);
    fork
      send_frame(8'h22, 1'b1, 1'b0, -1, 1'b0);
      begin
        idle(50);
        #1 rstn = 1'b0;
        exp_rd_q.delete();
        #1 check_reset_outputs("midframe_reset");
      end
    join
    idle(4);
    rstn = 1'b1;
    idle(10);
    chk("postreset_empty", rx_empty, 1);

    // Back-to-back at the minimum divisor
    bd = 16'd4;
    idle(10);
    send_frame(8'h01, 1'b1, 1'b0, -1, 1'b1);
    send_frame(8'h80, 1'b1, 1'b0, -1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, -1, 1'b1);
    idle(20);
    for (int i = 0; i < 3; i++) do_read();
    chk("b2b_empty", rx_empty, 1);

    // Randomised frames across divisors
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic       sb;
      bd = 16'($urandom_range(4, 24));
      d  = 8'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      idle(5);
      send_frame(d, sb, 1'b0, -1, 1'b1);
      idle(30);
      if (sb) do_read();
      chk("rand_empty", rx_empty, 1);
    end

    idle(10);
    chk("scoreboard_reads_left", exp_rd_q.size(), 0);
    chk("scoreboard_pulses_left", exp_evt_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
